countdown_timer: RTL and testbench

Loadable down-counter that complements the up-counter: software or an upstream FSM loads a tick count through a valid/ready handshake. The block decrements it on each enabled cycle and emits a one-cycle `done` pulse on reaching zero. It serves as the delay/timeout primitive for protocol FSMs, for example reset-release waits and UART bit timing.

---
 rtl/countdown_timer.sv | 144 ++++++++++++++
 tb/tb_countdown_timer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
// Loadable down-counter with a valid/ready load handshake. A loaded
// value N produces a one-cycle done pulse after N enabled cycles.
// A zero load pulses done immediately without entering RUN.
// Reset is synchronous and active-low on `reset`.
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN. When defined:
//   - a terminal count reloads from the reload register, and the timer stays in RUN;
//   - loads are also accepted while running.
// All outputs are flops, so there is no combinational path from inputs to outputs.

module countdown_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    localparam logic AUTO_RELOAD = 1'b1;
`else
    localparam logic AUTO_RELOAD = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             busy_r;
    logic             load_ready_r;
    logic             load_ready_nxt_s;
    logic             load_accept_s;
    logic             terminal_s;

    // Handshake qualification and terminal-count detection.
    always_comb begin
        load_accept_s = load_valid && load_ready_r;
        terminal_s    = (state_r == ST_RUN) && enable && (count_r == ONE);
    end

    // Next-state / next-count decode; priority is abort, load, decrement.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        reload_nxt_s = reload_r;
        done_nxt_s   = 1'b0;

        if (abort) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = ZERO;
        end else if (load_accept_s) begin
            if (load_value == ZERO) begin
                // Zero-length delay: report completion immediately.
                state_nxt_s  = ST_IDLE;
                count_nxt_s  = ZERO;
                reload_nxt_s = ZERO;
                done_nxt_s   = 1'b1;
            end else begin
                // A restart landing on the terminal edge still reports
                // the completion of the run it replaces.
                state_nxt_s  = ST_RUN;
                count_nxt_s  = load_value;
                reload_nxt_s = load_value;
                done_nxt_s   = terminal_s;
            end
        end else if ((state_r == ST_RUN) && enable) begin
            if (count_r > ONE) begin
                count_nxt_s = count_r - ONE;
            end else if (count_r == ONE) begin
                done_nxt_s = 1'b1;
                if (AUTO_RELOAD && (reload_r != ZERO)) begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = reload_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO;
                end
            end else begin
                // RUN with a zero count is unreachable; recover to IDLE.
                state_nxt_s = ST_IDLE;
                count_nxt_s = ZERO;
            end
        end else begin
            state_nxt_s = state_r;
            count_nxt_s = count_r;
        end
    end

    // Ready for the next cycle: always when auto-reloading, else only in IDLE.
    always_comb begin
        if (AUTO_RELOAD) begin
            load_ready_nxt_s = 1'b1;
        end else begin
            load_ready_nxt_s = (state_nxt_s == ST_IDLE);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            count_r      <= ZERO;
            reload_r     <= ZERO;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            reload_r     <= reload_nxt_s;
            done_r       <= done_nxt_s;
            busy_r       <= (state_nxt_s == ST_RUN);
            load_ready_r <= load_ready_nxt_s;
        end
    end

    // Drive ports straight from the flops.
    always_comb begin
        count      = count_r;
        busy       = busy_r;
        done       = done_r;
        load_ready = load_ready_r;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (WIDTH=8).
// Each step drives inputs, pushes the hand-derived expected outputs to a
// scoreboard queue, then pops and compares them just after the edge.
// Runs the auto-reload scenario when COUNTDOWN_TIMER_AUTO_RELOAD_EN is
// defined, otherwise the one-shot scenarios.

module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       abort;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_value;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    typedef struct {
        string      tag;
        logic [7:0] count;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];

    countdown_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .abort      (abort),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and compare outputs after the edge.
    task automatic step(input string tag, input logic rst, input logic en, input logic ab,
                        input logic lv, input logic [7:0] val,
                        input logic [7:0] e_count, input logic e_busy,
                        input logic e_done, input logic e_ready);
        exp_t e;
        reset      = rst;
        enable     = en;
        abort      = ab;
        load_valid = lv;
        load_value = val;
        exp_q.push_back('{tag, e_count, e_busy, e_done, e_ready});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val({e.tag, ".count"}, {24'd0, count}, {24'd0, e.count});
            check_val({e.tag, ".busy"},  {31'd0, busy},  {31'd0, e.busy});
            check_val({e.tag, ".done"},  {31'd0, done},  {31'd0, e.done});
            check_val({e.tag, ".ready"}, {31'd0, load_ready}, {31'd0, e.ready});
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        abort      = 1'b0;
        load_valid = 1'b0;
        load_value = 8'd0;

        //    tag        rst  en   ab   lv   val    count busy done ready
        step("rst0",     1'b0,1'b0,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b0);
        step("rst1",     1'b0,1'b0,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b0);
        step("idle",     1'b1,1'b0,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // Auto-reload: count 2,1,2,1 with done on every reload.
        step("ar_ld2",   1'b1,1'b1,1'b0,1'b1,8'd2,  8'd2, 1'b1,1'b0,1'b1);
        step("ar_c1",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b1);
        step("ar_t1",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd2, 1'b1,1'b1,1'b1);
        step("ar_c1b",   1'b1,1'b1,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b1);
        step("ar_t2",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd2, 1'b1,1'b1,1'b1);
        // Mid-run restart with 5.
        step("ar_ld5",   1'b1,1'b1,1'b0,1'b1,8'd5,  8'd5, 1'b1,1'b0,1'b1);
        step("ar_c4",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd4, 1'b1,1'b0,1'b1);
        step("ar_hold",  1'b1,1'b0,1'b0,1'b0,8'd0,  8'd4, 1'b1,1'b0,1'b1);
        step("ar_c3",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd3, 1'b1,1'b0,1'b1);
        step("ar_c2",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd2, 1'b1,1'b0,1'b1);
        step("ar_c1c",   1'b1,1'b1,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b1);
        // Load coincident with terminal: load wins, done still pulses.
        step("ar_ldt",   1'b1,1'b1,1'b0,1'b1,8'd3,  8'd3, 1'b1,1'b1,1'b1);
        step("ar_c2b",   1'b1,1'b1,1'b0,1'b0,8'd0,  8'd2, 1'b1,1'b0,1'b1);
        // Abort stops the run.
        step("ar_abort", 1'b1,1'b1,1'b1,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);
        step("ar_idle",  1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);
`else
        // One-shot: load 3, count 3,2,1,0 with done on the last edge.
        step("os_ld3",   1'b1,1'b1,1'b0,1'b1,8'd3,  8'd3, 1'b1,1'b0,1'b0);
        step("os_c2",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd2, 1'b1,1'b0,1'b0);
        step("os_c1",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b0);
        step("os_c0",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b1,1'b1);
        step("os_post",  1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);
        // Enable gating: load 2, pattern 1,0,0,1 gives 1,1,1,0.
        step("eg_ld2",   1'b1,1'b0,1'b0,1'b1,8'd2,  8'd2, 1'b1,1'b0,1'b0);
        step("eg_p1",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b0);
        step("eg_p0a",   1'b1,1'b0,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b0);
        step("eg_p0b",   1'b1,1'b0,1'b0,1'b0,8'd0,  8'd1, 1'b1,1'b0,1'b0);
        step("eg_p1b",   1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b1,1'b1);
        // Zero load pulses done without RUN, then back-to-back load 1.
        step("zl_ld0",   1'b1,1'b1,1'b0,1'b1,8'd0,  8'd0, 1'b0,1'b1,1'b1);
        step("zl_ld1",   1'b1,1'b0,1'b0,1'b1,8'd1,  8'd1, 1'b1,1'b0,1'b0);
        step("zl_t",     1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b1,1'b1);
        step("zl_post",  1'b1,1'b0,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);
        // Load offered during RUN is ignored.
        step("nr_ld3",   1'b1,1'b0,1'b0,1'b1,8'd3,  8'd3, 1'b1,1'b0,1'b0);
        step("nr_ld8",   1'b1,1'b0,1'b0,1'b1,8'd8,  8'd3, 1'b1,1'b0,1'b0);
        step("nr_c2",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd2, 1'b1,1'b0,1'b0);
        // Abort priority over a simultaneous load and decrement at count 4.
        step("ab_ld6",   1'b1,1'b1,1'b1,1'b1,8'd6,  8'd0, 1'b0,1'b0,1'b1);
        step("ab_ld6b",  1'b1,1'b0,1'b0,1'b1,8'd6,  8'd6, 1'b1,1'b0,1'b0);
        step("ab_c5",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd5, 1'b1,1'b0,1'b0);
        step("ab_c4",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd4, 1'b1,1'b0,1'b0);
        step("ab_hit",   1'b1,1'b1,1'b1,1'b1,8'd9,  8'd0, 1'b0,1'b0,1'b1);
        step("ab_post",  1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);
        // Reset held two edges mid-run at count 5.
        step("rr_ld7",   1'b1,1'b0,1'b0,1'b1,8'd7,  8'd7, 1'b1,1'b0,1'b0);
        step("rr_c6",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd6, 1'b1,1'b0,1'b0);
        step("rr_c5",    1'b1,1'b1,1'b0,1'b0,8'd0,  8'd5, 1'b1,1'b0,1'b0);
        step("rr_r0",    1'b0,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b0);
        step("rr_r1",    1'b0,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b0);
        step("rr_rel",   1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1);
        // Load 1 boundary after reset.
        step("rr_ld1",   1'b1,1'b1,1'b0,1'b1,8'd1,  8'd1, 1'b1,1'b0,1'b0);
        step("rr_t",     1'b1,1'b1,1'b0,1'b0,8'd0,  8'd0, 1'b0,1'b1,1'b1);
`endif

        check_val("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
